// File: rtl/ledwalk_pkg.sv
// ledwalk_pkg: command/mode/state encodings and index-width helper for the LED walker.
package ledwalk_pkg;
   typedef enum logic [1:0] {OP_STOP, OP_START, OP_SET_DIV, OP_SET_MODE} op_e;
   typedef enum logic [1:0] {M_BOUNCE, M_WRAP_UP, M_WRAP_DOWN} mode_e;
   typedef enum logic {S_IDLE, S_RUN} state_e;
   function automatic int iw(input int n);
      return n < 2 ? 1 : $clog2(n);
   endfunction
   function automatic mode_e to_mode(input logic [1:0] c);
      return c == 2'd3 ? M_BOUNCE : mode_e'(c);
   endfunction
endpackage

// File: rtl/ledwalk_if.sv
// ledwalk_if: valid/ready command port of the LED walker.
interface ledwalk_if #(parameter int DIVW = 24);
   logic            i_cmd_valid;
   logic            o_cmd_ready;
   logic [1:0]      i_cmd_op;
   logic [DIVW-1:0] i_cmd_data;
   modport master (output i_cmd_valid, i_cmd_op, i_cmd_data, input o_cmd_ready);
   modport slave (input i_cmd_valid, i_cmd_op, i_cmd_data, output o_cmd_ready);
endinterface

// File: rtl/ledwalk_decode.sv
// ledwalk_decode: registers the LED bus from the next index; LEDWALK_CTRL_TRAIL_EN adds a
// second lit LED at the previous position.
module ledwalk_decode
   import ledwalk_pkg::*;
#(
   parameter int NLEDS = 8,
   localparam int IW = iw(NLEDS)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [IW-1:0]    i_idx_nxt,
`ifdef LEDWALK_CTRL_TRAIL_EN
   input  logic [IW-1:0]    i_idx,
   input  logic             i_step,
   input  logic             i_clr,
`endif
   output logic [NLEDS-1:0] o_led
);
`ifdef LEDWALK_CTRL_TRAIL_EN
   logic [IW-1:0]    prev_q, prev_d;
   logic             tv_q, tv_d;
   logic [NLEDS-1:0] led_d;
   always_comb begin
      prev_d = i_step ? i_idx : prev_q;
      tv_d   = i_clr ? 1'b0 : (i_step || tv_q);
      led_d  = (NLEDS'(1) << i_idx_nxt) | (tv_d ? NLEDS'(1) << prev_d : '0);
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         prev_q <= '0;
         tv_q   <= 1'b0;
         o_led  <= NLEDS'(1);
      end else begin
         prev_q <= prev_d;
         tv_q   <= tv_d;
         o_led  <= led_d;
      end
   end
`else
   always_ff @(posedge i_clk) o_led <= i_reset ? NLEDS'(1) : NLEDS'(1) << i_idx_nxt;
`endif
endmodule

// File: rtl/ledwalk_ctrl.sv
// ledwalk_ctrl: walking-LED sequencer with run/stop/speed/mode commands over valid/ready.
// Optional LEDWALK_CTRL_TRAIL_EN lights the previous position as a two-hot trail.
module ledwalk_ctrl
   import ledwalk_pkg::*;
#(
   parameter int NLEDS       = 8,
   parameter int DIVW        = 24,
   parameter int DEFAULT_DIV = 1000000,
   localparam int IW = iw(NLEDS)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   ledwalk_if.slave         cmd,
   output logic [NLEDS-1:0] o_led,
   output logic [IW-1:0]    o_index,
   output logic             o_dir,
   output logic             o_stb,
   output logic             o_running
);
   localparam logic [IW-1:0] TOP = IW'(NLEDS - 1);
   state_e          state_q, state_d;
   mode_e           mode_q, mode_d, pmode_q, pmode_d, mode_use, new_mode;
   logic [IW-1:0]   idx_q, idx_d, nidx;
   logic            dir_q, dir_d, ndir, stb_q, pend_q, pend_d, rdy_q, rdy_d;
   logic [DIVW-1:0] div_q, div_d, cnt_q, cnt_d;
   logic            acc, run, stop, start, setdiv, setmode, step, apply, up;
   always_comb begin
      acc      = cmd.i_cmd_valid && rdy_q;
      run      = state_q == S_RUN;
      stop     = acc && cmd.i_cmd_op == OP_STOP;
      start    = acc && cmd.i_cmd_op == OP_START;
      setdiv   = acc && cmd.i_cmd_op == OP_SET_DIV;
      setmode  = acc && cmd.i_cmd_op == OP_SET_MODE;
      new_mode = to_mode(cmd.i_cmd_data[1:0]);
      step     = run && !stop && (div_q == '0 || cnt_q == div_q - 1'b1);
      apply    = pend_q && (step || stop);
      // a pending mode takes effect on the very step that applies it
      mode_use = pend_q ? pmode_q : mode_q;
      up       = mode_use == M_WRAP_UP ||
                 (mode_use == M_BOUNCE && (dir_q ? idx_q == '0 : idx_q != TOP));
      nidx     = up ? (idx_q == TOP ? '0 : idx_q + 1'b1) : (idx_q == '0 ? TOP : idx_q - 1'b1);
      ndir     = mode_use == M_WRAP_UP ? 1'b0 : mode_use == M_WRAP_DOWN ? 1'b1 :
                 up ? nidx == TOP : nidx != '0;
      state_d  = start ? S_RUN : stop ? S_IDLE : state_q;
      cnt_d    = (setdiv || step || (start && !run)) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      div_d    = setdiv ? cmd.i_cmd_data : div_q;
      mode_d   = (setmode && !run) ? new_mode : apply ? pmode_q : mode_q;
      pmode_d  = (setmode && run) ? new_mode : pmode_q;
      pend_d   = (setmode && run) || (pend_q && !apply);
      idx_d    = step ? nidx : idx_q;
      dir_d    = step ? ndir : dir_q;
      rdy_d    = !pend_d;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         mode_q  <= M_BOUNCE;
         pmode_q <= M_BOUNCE;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         stb_q   <= 1'b0;
         pend_q  <= 1'b0;
         rdy_q   <= 1'b0;
         div_q   <= DIVW'(DEFAULT_DIV);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pmode_q <= pmode_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         stb_q   <= step;
         pend_q  <= pend_d;
         rdy_q   <= rdy_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
      end
   end
   assign cmd.o_cmd_ready = rdy_q;
   assign o_index         = idx_q;
   assign o_dir           = dir_q;
   assign o_stb           = stb_q;
   assign o_running       = run;
   ledwalk_decode #(.NLEDS(NLEDS)) u_decode (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_idx_nxt (idx_d),
`ifdef LEDWALK_CTRL_TRAIL_EN
      .i_idx     (idx_q),
      .i_step    (step),
      .i_clr     (start || (setmode && !run) || apply),
`endif
      .o_led     (o_led)
   );
   a_index: assert property (@(posedge i_clk) disable iff (i_reset) 32'(o_index) < NLEDS);
`ifndef LEDWALK_CTRL_TRAIL_EN
   a_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot(o_led));
`endif
endmodule
